// File: rtl/memory_dp.sv
// Simple-dual-port synchronous RAM: one write port, one registered read port,
// and a clear engine that zero-fills the array after reset or on request.
module memory_dp #(
   parameter int N   = 8,
   parameter int A   = 8,
   parameter bit CLR = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [N-1:0] write,
   input  logic         re,
   input  logic [A-1:0] raddr,
   input  logic         clr_req,
   output logic [N-1:0] read,
   output logic         rvalid,
   output logic         busy
);

   localparam int DEPTH = 2 ** A;
   localparam logic [A-1:0] CNT_ONE  = {{(A-1){1'b0}}, 1'b1};
   localparam logic [A-1:0] CNT_LAST = '1;

   typedef enum logic {
      CLEARING = 1'b0,
      READY    = 1'b1
   } state_t;

   localparam state_t RST_STATE = CLR ? CLEARING : READY;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [A-1:0] r_cnt;
   logic [A-1:0] w_cnt_nxt;
   logic         w_wr_acc;
   logic         w_rd_acc;
   logic         w_mem_we;
   logic [A-1:0] w_mem_addr;
   logic [N-1:0] w_mem_data;
   logic [N-1:0] w_rd_data;
   logic [N-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RST_STATE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A clear request in READY wins over any access presented on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wr_acc    = 1'b0;
      w_rd_acc    = 1'b0;
      case (r_state)
         CLEARING: begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = READY;
            end
         end
         READY: begin
            if (CLR && clr_req) begin
               w_state_nxt = CLEARING;
               w_cnt_nxt   = '0;
            end else begin
               w_wr_acc = we;
               w_rd_acc = re;
            end
         end
         default: begin
            w_state_nxt = RST_STATE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      w_mem_we   = w_wr_acc;
      w_mem_addr = waddr;
      w_mem_data = write;
      if (r_state == CLEARING) begin
         w_mem_we   = 1'b1;
         w_mem_addr = r_cnt;
         w_mem_data = '0;
      end
   end

   // Storage has no reset; the clear engine provides defined contents.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // Write-first bypass when both ports hit the same word on one edge.
   assign w_rd_data = (w_wr_acc && (waddr == raddr)) ? write : r_mem[raddr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read   <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= w_rd_acc;
         if (w_rd_acc) begin
            read <= w_rd_data;
         end
      end
   end

   assign busy = (r_state == CLEARING);

endmodule

// File: tb/tb_memory_dp.sv
// Scoreboard bench for memory_dp: randomized and directed traffic against an
// array-based reference model, plus a small CLR=0 instance.
module tb_memory_dp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, we, re, clr_req;
   logic [7:0] waddr, raddr, wdata, rdata;
   logic       rvalid, busy;

   logic       rst0, we0, re0, clr0;
   logic [3:0] waddr0, raddr0;
   logic [7:0] wdata0, rdata0;
   logic       rvalid0, busy0;

   memory_dp #(.N(8), .A(8), .CLR(1'b1)) dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .write(wdata),
      .re(re), .raddr(raddr), .clr_req(clr_req),
      .read(rdata), .rvalid(rvalid), .busy(busy)
   );

   memory_dp #(.N(8), .A(4), .CLR(1'b0)) dut0 (
      .clk(clk), .rst(rst0), .we(we0), .waddr(waddr0), .write(wdata0),
      .re(re0), .raddr(raddr0), .clr_req(clr0),
      .read(rdata0), .rvalid(rvalid0), .busy(busy0)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] mdl [256];
   int         clear_left = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_hold = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every rvalid pulse consumes one expected word; otherwise read must hold.
   always @(negedge clk) begin
      if (rst) exp_hold = 8'h00;
      if (rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("rvalid_spurious", {31'd0, rvalid}, 32'd0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("read_data", {24'd0, rdata}, {24'd0, e});
            exp_hold = e;
         end
      end else begin
         chk("read_hold", {24'd0, rdata}, {24'd0, exp_hold});
      end
   end

   task automatic zero_model();
      for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1; we = 1'b0; re = 1'b0; clr_req = 1'b0;
      waddr = 8'h00; raddr = 8'h00; wdata = 8'h00;
      #1;
      chk("rst_read",   {24'd0, rdata}, 32'd0);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_busy",   {31'd0, busy}, 32'd1);
      exp_q.delete();
      repeat (hold) @(posedge clk);
      #1 rst = 1'b0;
      zero_model();
      clear_left = 256;
      chk("busy_after_release", {31'd0, busy}, 32'd1);
   endtask

   task automatic cycle(input bit iwe, input int wa, input int wd,
                        input bit ire, input int ra, input bit iclr);
      we = iwe; waddr = wa[7:0]; wdata = wd[7:0];
      re = ire; raddr = ra[7:0]; clr_req = iclr;
      @(posedge clk);
      if (clear_left > 0) begin
         clear_left--;
      end else if (iclr) begin
         zero_model();
         clear_left = 256;
      end else begin
         if (ire) exp_q.push_back((iwe && wa[7:0] == ra[7:0]) ? wd[7:0] : mdl[ra[7:0]]);
         if (iwe) mdl[wa[7:0]] = wd[7:0];
      end
      #1;
      chk("busy", {31'd0, busy}, {31'd0, (clear_left > 0)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic rd(input int a);
      cycle(1'b0, 0, 0, 1'b1, a, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst0 = 1'b1; we0 = 1'b0; re0 = 1'b0; clr0 = 1'b0;
      waddr0 = 4'h0; raddr0 = 4'h0; wdata0 = 8'h00;

      // Reset clear and readback of cleared words
      do_reset(2);
      idle(256);
      rd(8'h00); rd(8'h7F); idle(1); rd(8'hFF); idle(2);

      // Full sweep
      for (int i = 0; i < 256; i++) cycle(1'b1, i, i, 1'b0, 0, 1'b0);
      for (int i = 0; i < 256; i++) rd(i);
      idle(3);

      // Collisions
      cycle(1'b1, 8'h10, 8'h11, 1'b0, 0, 1'b0);
      cycle(1'b1, 8'h10, 8'hA5, 1'b1, 8'h10, 1'b0);
      cycle(1'b1, 8'h21, 8'h77, 1'b0, 0, 1'b0);
      cycle(1'b1, 8'h20, 8'h3C, 1'b1, 8'h21, 1'b0);
      rd(8'h20); idle(2);

      // clr_req priority, access during clear, repeated request mid-clear
      cycle(1'b1, 8'h40, 8'h99, 1'b1, 8'h40, 1'b1);
      for (int k = 0; k < 256; k++) begin
         if (k == 10)      cycle(1'b1, 8'h05, 8'hEE, 1'b1, 8'h05, 1'b0);
         else if (k == 50) cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
         else              idle(1);
      end
      rd(8'h40); rd(8'h05); rd(8'h10); idle(2);

      // Randomized traffic
      for (int i = 0; i < 120; i++) cycle(1'b1, i % 16, $urandom_range(0, 255), 1'b0, 0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         int wa, ra;
         wa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
         ra = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
         cycle($urandom_range(0, 1) == 1, wa, $urandom_range(0, 255),
               $urandom_range(0, 2) != 0, ra, $urandom_range(0, 149) == 0);
      end
      for (int i = 0; i < 300 && clear_left > 0; i++) idle(1);

      // Reset mid-clear
      cycle(1'b1, 8'h33, 8'h5A, 1'b0, 0, 1'b0);
      rd(8'h33);
      cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
      idle(100);
      do_reset(2);
      idle(256);
      rd(8'h33); rd(8'hFF); idle(2);

      // CLR=0 instance
      #1;
      chk("c0_rst_busy",   {31'd0, busy0}, 32'd0);
      chk("c0_rst_read",   {24'd0, rdata0}, 32'd0);
      chk("c0_rst_rvalid", {31'd0, rvalid0}, 32'd0);
      @(posedge clk); #1 rst0 = 1'b0;
      chk("c0_busy", {31'd0, busy0}, 32'd0);
      we0 = 1'b1; waddr0 = 4'hF; wdata0 = 8'h3C;
      @(posedge clk); #1;
      we0 = 1'b0; re0 = 1'b1; raddr0 = 4'hF;
      @(posedge clk); #1;
      chk("c0_rvalid", {31'd0, rvalid0}, 32'd1);
      chk("c0_read",   {24'd0, rdata0}, 32'h3C);
      re0 = 1'b0; clr0 = 1'b1; we0 = 1'b1; waddr0 = 4'h5; wdata0 = 8'h12;
      @(posedge clk); #1;
      chk("c0_clr_busy", {31'd0, busy0}, 32'd0);
      clr0 = 1'b0; we0 = 1'b0; re0 = 1'b1; raddr0 = 4'h5;
      @(posedge clk); #1;
      chk("c0_clr_read", {24'd0, rdata0}, 32'h12);
      chk("c0_clr_rvalid", {31'd0, rvalid0}, 32'd1);
      re0 = 1'b0;

      idle(3);
      chk("drain", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
